rob_multi_commit: RTL and testbench
===================================

// Module: rob_multi_commit
// PURPOSE
//   Parametrised in-order reorder buffer for the Tomasulo core: DEPTH-entry circular queue,
//   CDB_N result-broadcast channels, and up to COMMIT_W in-order retirements per cycle.
//   Sits between decoder (issue), ALU/LSB (CDB), and register file/LSB/fetcher (commit, rollback).
//   All DEPTH entries are usable; mispredict flush takes effect on the same edge as the commit.
// PARAMETERS
//   DEPTH     16  entries; power of two, >=4
//   TAG_W     5   tag width, $clog2(DEPTH)+1; tag = index+1, tag 0 = NULL
//   CDB_N     2   broadcast channels
//   COMMIT_W  2   commit slots per cycle, 1..4
// PORTS
//   clk              in   1             clock, rising edge
//   rst              in   1             synchronous, active-high reset
//   issue_valid      in   1             allocate entry at tail this cycle
//   issue_opcode     in   7             inst[6:0]
//   issue_rd         in   5             destination register
//   issue_pc         in   32            instruction pc
//   issue_imm        in   32            immediate; branch target = pc+imm
//   issue_pred_pc    in   32            fetcher-predicted next pc
//   alloc_tag        out  TAG_W         tag for the next issue; NULL when full (comb)
//   full             out  1             count==DEPTH (comb)
//   count_out        out  TAG_W         occupancy 0..DEPTH (reg)
//   qj, qk           in   TAG_W each    operand lookup tags
//   vj_ready, vk_ready out 1 each       operand available (comb)
//   vj, vk           out  32 each       operand value (comb)
//   cdb_valid        in   CDB_N         per-channel strobe
//   cdb_tag          in   CDB_N*TAG_W   channel k at [k*TAG_W +: TAG_W]
//   cdb_data         in   CDB_N*32      result
//   cdb_new_pc       in   CDB_N*32      resolved next pc (control ops)
//   commit_valid     out  COMMIT_W      slot i retires; slot 0 oldest
//   commit_rf_we     out  COMMIT_W      write RF (not BRANCH, not STORE)
//   commit_store     out  COMMIT_W      release store in LSB
//   commit_tag/rd/data out COMMIT_W*(TAG_W/5/32)  per-slot fields
//   rollback         out  1             one-cycle flush pulse
//   rollback_pc      out  32            redirect pc
//   bp_update        out  COMMIT_W      slot retired a BRANCH
//   bp_taken         out  COMMIT_W      new_pc == pc+imm
// BEHAVIOUR
// - rst dominates every other event: head=tail=count=0, all ready/valid cleared; all registered outputs 0.
// - Issue: issue_valid && !full writes entry at tail (ready=0), tail wraps DEPTH-1 -> 0. Issue while full is
//   dropped (assertion). full ignores same-cycle commits.
// - CDB: channel k writes data/new_pc and sets ready only if its tag is occupied; stale/NULL tags are ignored.
//   Two channels with the same tag: higher k wins (assertion flags it).
// - Lookup: ready = occupied && (ready || matching CDB this cycle); the CDB value bypasses the stored value.
//   NULL/unoccupied tag -> ready=0, value don't-care.
// - Commit (registered, 1-cycle latency): slot i examines entry head+i. It retires iff i<count, the entry is
//   ready or opcode==STORE, all slots <i retire, no slot <i is a mispredict, and it is not a second STORE this
//   cycle. An entry made ready by CDB at cycle t retires no earlier than edge t+1. head and count advance by
//   the number retired; count = count + issued - retired.
// - Mispredict: a BRANCH or JALR entry with new_pc != pred_pc retires in its slot and later slots are
//   suppressed. On that edge: rollback<=1, rollback_pc<=new_pc, head=tail=count=0; that cycle's issue and CDB
//   writes are discarded. rollback is high for exactly one cycle.
// - bp_update/bp_taken are valid per retiring BRANCH slot, including a mispredicting one.
// - Empty: no commit; alloc_tag=1 after reset or flush.
// TESTING
// 1. Reset, issue 16 ALU ops, no CDB -> full=1, alloc_tag=0, count_out=16; 17th issue ignored.
// 2. CDB tag3=0x55 (ch0) and tag1=0x11 (ch1), tag2 pending -> next cycle commit_valid=01, tag1, data 0x11.
//    Then tag2 ready -> tags 2,3 retire in one cycle.
// 3. Tag1 BRANCH pred 0x104, new_pc 0x200; tag2 ready -> only tag1 retires; rollback=1, rollback_pc=0x200;
//    count_out=0; next alloc_tag=1.
// 4. Two STOREs at head -> one commit_store per cycle, commit_rf_we=0.
// 5. Stream 40 ops with random CDB order -> tags wrap 16 -> 1; retirement stays in program order.
// 6. qj=5 while cdb tag5=0xAB -> vj_ready=1 and vj=0xAB in the same cycle; rst mid-stream -> all outputs 0.

Source files
------------

// File: rtl/rob_multi_commit.sv
// In-order reorder buffer: circular queue with multi-channel CDB capture, operand bypass lookup,
// and up to COMMIT_W in-order retirements per cycle with same-edge mispredict flush.

module rob_slot_decode (
    input  logic        occ,
    input  logic        ready,
    input  logic [6:0]  opcode,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] pred_pc,
    input  logic [31:0] new_pc,
    output logic        elig,
    output logic        store,
    output logic        branch,
    output logic        mispred,
    output logic        taken
);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    assign store   = (opcode == OP_STORE);
    assign branch  = (opcode == OP_BRANCH);
    // Stores release without a CDB result; everything else waits for ready.
    assign elig    = occ && (ready || store);
    assign mispred = (branch || opcode == OP_JALR) && (new_pc != pred_pc);
    assign taken   = (new_pc == pc + imm);
endmodule

module rob_multi_commit #(
    parameter int DEPTH    = 16,
    parameter int TAG_W    = 5,
    parameter int CDB_N    = 2,
    parameter int COMMIT_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [6:0]                issue_opcode,
    input  logic [4:0]                issue_rd,
    input  logic [31:0]               issue_pc,
    input  logic [31:0]               issue_imm,
    input  logic [31:0]               issue_pred_pc,
    output logic [TAG_W-1:0]          alloc_tag,
    output logic                      full,
    output logic [TAG_W-1:0]          count_out,
    input  logic [TAG_W-1:0]          qj,
    input  logic [TAG_W-1:0]          qk,
    output logic                      vj_ready,
    output logic                      vk_ready,
    output logic [31:0]               vj,
    output logic [31:0]               vk,
    input  logic [CDB_N-1:0]          cdb_valid,
    input  logic [CDB_N*TAG_W-1:0]    cdb_tag,
    input  logic [CDB_N*32-1:0]       cdb_data,
    input  logic [CDB_N*32-1:0]       cdb_new_pc,
    output logic [COMMIT_W-1:0]       commit_valid,
    output logic [COMMIT_W-1:0]       commit_rf_we,
    output logic [COMMIT_W-1:0]       commit_store,
    output logic [COMMIT_W*TAG_W-1:0] commit_tag,
    output logic [COMMIT_W*5-1:0]     commit_rd,
    output logic [COMMIT_W*32-1:0]    commit_data,
    output logic                      rollback,
    output logic [31:0]               rollback_pc,
    output logic [COMMIT_W-1:0]       bp_update,
    output logic [COMMIT_W-1:0]       bp_taken
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] pred_pc;
        logic [31:0] data;
        logic [31:0] new_pc;
    } rob_entry_t;

    rob_entry_t        ent [DEPTH];
    logic [DEPTH-1:0]  valid, ready;
    logic [IDX_W-1:0]  head, tail;
    logic [TAG_W-1:0]  count;

    function automatic logic tag_ok(input logic [TAG_W-1:0] t);
        return (t != '0) && (t <= TAG_W'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] t);
        logic [TAG_W-1:0] m;
        m = t - TAG_W'(1);
        return m[IDX_W-1:0];
    endfunction

    logic do_issue;
    assign full      = (count == TAG_W'(DEPTH));
    assign alloc_tag = full ? '0 : TAG_W'(tail) + TAG_W'(1);
    assign count_out = count;
    assign do_issue  = issue_valid && !full;

    // CDB unpack and occupancy filter
    logic [CDB_N-1:0][TAG_W-1:0] c_tag;
    logic [CDB_N-1:0][31:0]      c_data, c_npc;
    logic [CDB_N-1:0][IDX_W-1:0] c_idx;
    logic [CDB_N-1:0]            c_hit;
    assign c_tag  = cdb_tag;
    assign c_data = cdb_data;
    assign c_npc  = cdb_new_pc;

    always_comb begin
        for (int k = 0; k < CDB_N; k++) begin
            c_idx[k] = tag_idx(c_tag[k]);
            c_hit[k] = cdb_valid[k] && tag_ok(c_tag[k]) && valid[c_idx[k]];
        end
    end

    // Operand lookup; a same-cycle broadcast bypasses the stored value, higher channel wins.
    logic [1:0][TAG_W-1:0] q_tag;
    logic [1:0]            q_rdy;
    logic [1:0][31:0]      q_val;
    assign q_tag = {qk, qj};

    always_comb begin
        for (int o = 0; o < 2; o++) begin
            q_rdy[o] = 1'b0;
            q_val[o] = ent[tag_idx(q_tag[o])].data;
            if (tag_ok(q_tag[o]) && valid[tag_idx(q_tag[o])]) begin
                q_rdy[o] = ready[tag_idx(q_tag[o])];
                for (int k = 0; k < CDB_N; k++) begin
                    if (cdb_valid[k] && c_tag[k] == q_tag[o]) begin
                        q_rdy[o] = 1'b1;
                        q_val[o] = c_data[k];
                    end
                end
            end
        end
    end

    assign vj_ready = q_rdy[0];
    assign vk_ready = q_rdy[1];
    assign vj       = q_val[0];
    assign vk       = q_val[1];

    // Commit window gather
    logic [COMMIT_W-1:0][IDX_W-1:0] s_idx;
    logic [COMMIT_W-1:0]            s_occ, s_ready;
    logic [COMMIT_W-1:0][6:0]       s_op;
    logic [COMMIT_W-1:0][31:0]      s_pc, s_imm, s_pred, s_npc;
    logic [COMMIT_W-1:0]            s_elig, s_store, s_br, s_mis, s_taken;

    always_comb begin
        for (int i = 0; i < COMMIT_W; i++) begin
            s_idx[i]   = head + IDX_W'(i);
            s_occ[i]   = TAG_W'(i) < count;
            s_ready[i] = ready[s_idx[i]];
            s_op[i]    = ent[s_idx[i]].opcode;
            s_pc[i]    = ent[s_idx[i]].pc;
            s_imm[i]   = ent[s_idx[i]].imm;
            s_pred[i]  = ent[s_idx[i]].pred_pc;
            s_npc[i]   = ent[s_idx[i]].new_pc;
        end
    end

    rob_slot_decode u_slot [COMMIT_W-1:0] (
        .occ    (s_occ),
        .ready  (s_ready),
        .opcode (s_op),
        .pc     (s_pc),
        .imm    (s_imm),
        .pred_pc(s_pred),
        .new_pc (s_npc),
        .elig   (s_elig),
        .store  (s_store),
        .branch (s_br),
        .mispred(s_mis),
        .taken  (s_taken)
    );

    // Retire chain: contiguous prefix, at most one store, stop after a mispredict.
    logic [COMMIT_W-1:0]            ret_n, we_n, st_n, bpu_n, bpt_n;
    logic [COMMIT_W-1:0][TAG_W-1:0] ctag_n;
    logic [COMMIT_W-1:0][4:0]       crd_n;
    logic [COMMIT_W-1:0][31:0]      cdata_n;
    logic [TAG_W-1:0]               n_ret;
    logic                           flush;
    logic [31:0]                    flush_pc;

    always_comb begin
        logic go, seen;
        go       = 1'b1;
        seen     = 1'b0;
        n_ret    = '0;
        flush    = 1'b0;
        flush_pc = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            ret_n[i]   = go && s_elig[i] && !(s_store[i] && seen);
            we_n[i]    = ret_n[i] && !s_br[i] && !s_store[i];
            st_n[i]    = ret_n[i] && s_store[i];
            bpu_n[i]   = ret_n[i] && s_br[i];
            bpt_n[i]   = bpu_n[i] && s_taken[i];
            ctag_n[i]  = ret_n[i] ? TAG_W'(s_idx[i]) + TAG_W'(1) : '0;
            crd_n[i]   = ret_n[i] ? ent[s_idx[i]].rd : '0;
            cdata_n[i] = ret_n[i] ? ent[s_idx[i]].data : '0;
            if (ret_n[i]) begin
                n_ret = n_ret + TAG_W'(1);
                if (s_store[i]) seen = 1'b1;
                if (s_mis[i]) begin
                    flush    = 1'b1;
                    flush_pc = s_npc[i];
                end
            end
            go = ret_n[i] && !s_mis[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            valid        <= '0;
            ready        <= '0;
            commit_valid <= '0;
            commit_rf_we <= '0;
            commit_store <= '0;
            commit_tag   <= '0;
            commit_rd    <= '0;
            commit_data  <= '0;
            bp_update    <= '0;
            bp_taken     <= '0;
            rollback     <= 1'b0;
            rollback_pc  <= '0;
        end else begin
            commit_valid <= ret_n;
            commit_rf_we <= we_n;
            commit_store <= st_n;
            commit_tag   <= ctag_n;
            commit_rd    <= crd_n;
            commit_data  <= cdata_n;
            bp_update    <= bpu_n;
            bp_taken     <= bpt_n;
            rollback     <= flush;
            if (flush) begin
                rollback_pc <= flush_pc;
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                valid       <= '0;
                ready       <= '0;
            end else begin
                for (int k = 0; k < CDB_N; k++) begin
                    if (c_hit[k]) begin
                        ent[c_idx[k]].data   <= c_data[k];
                        ent[c_idx[k]].new_pc <= c_npc[k];
                        ready[c_idx[k]]      <= 1'b1;
                    end
                end
                // Retire clears come after CDB writes so they take priority.
                for (int i = 0; i < COMMIT_W; i++) begin
                    if (ret_n[i]) begin
                        valid[s_idx[i]] <= 1'b0;
                        ready[s_idx[i]] <= 1'b0;
                    end
                end
                if (do_issue) begin
                    ent[tail] <= '{opcode: issue_opcode, rd: issue_rd, pc: issue_pc, imm: issue_imm,
                                   pred_pc: issue_pred_pc, data: '0, new_pc: '0};
                    valid[tail] <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + IDX_W'(1);
                end
                head  <= head + IDX_W'(n_ret);
                count <= count + TAG_W'(do_issue) - n_ret;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(issue_valid && full)) else $warning("rob: issue while full dropped");
            for (int a = 0; a < CDB_N; a++)
                for (int b = a + 1; b < CDB_N; b++)
                    assert (!(cdb_valid[a] && cdb_valid[b] && c_tag[a] == c_tag[b] && c_tag[a] != '0))
                        else $warning("rob: duplicate cdb tag on two channels");
        end
    end
endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit; retirements are checked against an in-order scoreboard.

module tb_rob_multi_commit;
    localparam int DEPTH = 16, TAG_W = 5, CDB_N = 2, COMMIT_W = 2;
    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_ST  = 7'b0100011;

    logic clk, rst;
    logic issue_valid;
    logic [6:0] issue_opcode;
    logic [4:0] issue_rd;
    logic [31:0] issue_pc, issue_imm, issue_pred_pc;
    logic [TAG_W-1:0] alloc_tag, count_out, qj, qk;
    logic full, vj_ready, vk_ready, rollback;
    logic [31:0] vj, vk, rollback_pc;
    logic [CDB_N-1:0] cdb_valid;
    logic [CDB_N*TAG_W-1:0] cdb_tag;
    logic [CDB_N*32-1:0] cdb_data, cdb_new_pc;
    logic [COMMIT_W-1:0] commit_valid, commit_rf_we, commit_store, bp_update, bp_taken;
    logic [COMMIT_W*TAG_W-1:0] commit_tag;
    logic [COMMIT_W*5-1:0] commit_rd;
    logic [COMMIT_W*32-1:0] commit_data;

    rob_multi_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CDB_N(CDB_N), .COMMIT_W(COMMIT_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_rd(issue_rd),
        .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_pred_pc(issue_pred_pc),
        .alloc_tag(alloc_tag), .full(full), .count_out(count_out),
        .qj(qj), .qk(qk), .vj_ready(vj_ready), .vk_ready(vk_ready), .vj(vj), .vk(vk),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_new_pc(cdb_new_pc),
        .commit_valid(commit_valid), .commit_rf_we(commit_rf_we), .commit_store(commit_store),
        .commit_tag(commit_tag), .commit_rd(commit_rd), .commit_data(commit_data),
        .rollback(rollback), .rollback_pc(rollback_pc),
        .bp_update(bp_update), .bp_taken(bp_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    int exp_tag;
    logic [63:0] sb[$];
    logic [36:0] pend[$];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [4:0] t, input logic [4:0] rd, input logic [31:0] d,
                                       input logic we, input logic st, input logic bu, input logic bt);
        return {18'd0, t, rd, d, we, st, bu, bt};
    endfunction

    function automatic logic [31:0] t1_data(input int t);
        return (t == 1) ? 32'h11 : (t == 2) ? 32'h22 : (t == 3) ? 32'h55 : 32'h100 + 32'(t);
    endfunction

    task automatic check_commits();
        chk("commit_prefix", 64'(commit_valid & (commit_valid + 1'b1)), 64'd0);
        for (int i = 0; i < COMMIT_W; i++) begin
            if (commit_valid[i]) begin
                logic [63:0] obs;
                obs = pk(commit_tag[i*TAG_W +: TAG_W], commit_rd[i*5 +: 5], commit_data[i*32 +: 32],
                         commit_rf_we[i], commit_store[i], bp_update[i], bp_taken[i]);
                chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) chk("commit_slot", obs, sb.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_commits();
        issue_valid = 1'b0;
        cdb_valid   = '0;
    endtask

    task automatic do_issue(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [31:0] pred, output logic [4:0] tag);
        issue_valid = 1'b1; issue_opcode = op; issue_rd = rd;
        issue_pc = pc; issue_imm = imm; issue_pred_pc = pred;
        #1;
        chk("alloc_tag", 64'(alloc_tag), 64'(exp_tag));
        tag = 5'(exp_tag);
        exp_tag = exp_tag % DEPTH + 1;
    endtask

    task automatic cdb(input int ch, input logic [4:0] tag, input logic [31:0] data, input logic [31:0] npc);
        cdb_valid[ch] = 1'b1;
        cdb_tag[ch*TAG_W +: TAG_W] = tag;
        cdb_data[ch*32 +: 32] = data;
        cdb_new_pc[ch*32 +: 32] = npc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] tg;
        int issued, idx;
        logic [36:0] fresh, e;
        bit has_fresh;

        rst = 1'b1; issue_valid = 1'b0; issue_opcode = '0; issue_rd = '0;
        issue_pc = '0; issue_imm = '0; issue_pred_pc = '0;
        qj = '0; qk = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0; cdb_new_pc = '0;
        exp_tag = 1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_count", 64'(count_out), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_alloc", 64'(alloc_tag), 64'd1);
        chk("rst_rollback", 64'(rollback), 64'd0);
        chk("rst_cvalid", 64'(commit_valid), 64'd0);

        // Fill all 16 entries with unready ALU ops
        for (int i = 0; i < DEPTH; i++) begin
            do_issue(OP_ALU, 5'(i + 1), 32'h1000 + 32'(4 * i), 32'd0, 32'h1004 + 32'(4 * i), tg);
            sb.push_back(pk(tg, 5'(i + 1), t1_data(int'(tg)), 1'b1, 1'b0, 1'b0, 1'b0));
            tick();
        end
        chk("t1_full", 64'(full), 64'd1);
        chk("t1_alloc_null", 64'(alloc_tag), 64'd0);
        chk("t1_count16", 64'(count_out), 64'd16);
        issue_valid = 1'b1; issue_opcode = OP_ALU; issue_rd = 5'd30;
        tick();
        chk("t1_drop_count", 64'(count_out), 64'd16);
        chk("t1_drop_alloc", 64'(alloc_tag), 64'd0);

        // Out-of-order results; only the ready prefix retires
        cdb(0, 5'd3, 32'h55, 32'd0);
        cdb(1, 5'd1, 32'h11, 32'd0);
        tick();
        chk("t2_no_early", 64'(commit_valid), 64'd0);
        tick();
        chk("t2_cv01", 64'(commit_valid), 64'b01);
        chk("t2_tag1", 64'(commit_tag[TAG_W-1:0]), 64'd1);
        chk("t2_data", 64'(commit_data[31:0]), 64'h11);
        cdb(0, 5'd2, 32'h22, 32'd0);
        tick();
        tick();
        chk("t2_cv11", 64'(commit_valid), 64'b11);
        chk("t2_count13", 64'(count_out), 64'd13);
        for (int t = 4; t <= DEPTH; t += 2) begin
            cdb(0, 5'(t), t1_data(t), 32'd0);
            if (t + 1 <= DEPTH) cdb(1, 5'(t + 1), t1_data(t + 1), 32'd0);
            tick();
        end
        for (int n = 0; n < 20 && count_out != 0; n++) tick();
        chk("t2_drained", 64'(count_out), 64'd0);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // Mispredicting branch at head flushes younger ready op and same-cycle issue
        do_issue(OP_BR, 5'd0, 32'h100, 32'h100, 32'h104, tg);
        sb.push_back(pk(tg, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1));
        tick();
        do_issue(OP_ALU, 5'd7, 32'h104, 32'd0, 32'h108, tg);
        tick();
        cdb(0, 5'd1, 32'd0, 32'h200);
        cdb(1, 5'd2, 32'h77, 32'd0);
        tick();
        chk("t3_no_early", 64'(commit_valid), 64'd0);
        issue_valid = 1'b1; issue_opcode = OP_ALU; issue_rd = 5'd8;
        tick();
        exp_tag = 1;
        chk("t3_rollback", 64'(rollback), 64'd1);
        chk("t3_rollback_pc", 64'(rollback_pc), 64'h200);
        chk("t3_count0", 64'(count_out), 64'd0);
        chk("t3_alloc1", 64'(alloc_tag), 64'd1);
        chk("t3_cv01", 64'(commit_valid), 64'b01);
        tick();
        chk("t3_pulse", 64'(rollback), 64'd0);
        chk("t3_alloc_after", 64'(alloc_tag), 64'd1);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Two stores reach the head together; one store per cycle
        do_issue(OP_ALU, 5'd9, 32'h300, 32'd0, 32'h304, tg);
        sb.push_back(pk(tg, 5'd9, 32'h31, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        do_issue(OP_ALU, 5'd10, 32'h304, 32'd0, 32'h308, tg);
        sb.push_back(pk(tg, 5'd10, 32'h32, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        do_issue(OP_ST, 5'd11, 32'h308, 32'd0, 32'h30c, tg);
        sb.push_back(pk(tg, 5'd11, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        do_issue(OP_ST, 5'd12, 32'h30c, 32'd0, 32'h310, tg);
        sb.push_back(pk(tg, 5'd12, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        cdb(0, 5'd1, 32'h31, 32'd0);
        cdb(1, 5'd2, 32'h32, 32'd0);
        tick();
        for (int n = 0; n < 10 && count_out != 0; n++) begin
            tick();
            chk("t4_one_store", 64'($countones(commit_store) <= 1), 64'd1);
        end
        chk("t4_drained", 64'(count_out), 64'd0);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // 40-op stream with random result order; tags wrap 16 -> 1
        issued = 0;
        for (int cyc = 0; cyc < 400 && (issued < 40 || count_out != 0); cyc++) begin
            has_fresh = 1'b0;
            fresh = '0;
            if (issued < 40 && !full) begin
                do_issue(OP_ALU, 5'(issued), 32'h2000 + 32'(4 * issued), 32'd0, 32'h2004 + 32'(4 * issued), tg);
                sb.push_back(pk(tg, 5'(issued), 32'h5000 + 32'(issued), 1'b1, 1'b0, 1'b0, 1'b0));
                fresh = {tg, 32'h5000 + 32'(issued)};
                has_fresh = 1'b1;
                issued++;
            end
            for (int ch = 0; ch < CDB_N; ch++) begin
                if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
                    idx = $urandom_range(0, pend.size() - 1);
                    e = pend[idx];
                    pend.delete(idx);
                    cdb(ch, e[36:32], e[31:0], 32'd0);
                end
            end
            tick();
            if (has_fresh) pend.push_back(fresh);
        end
        chk("t5_issued", 64'(issued), 64'd40);
        chk("t5_drained", 64'(count_out), 64'd0);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        // Lookup bypass, then reset mid-stream
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        exp_tag = 1;
        for (int i = 0; i < 6; i++) begin
            do_issue(OP_ALU, 5'(20 + i), 32'h400 + 32'(4 * i), 32'd0, 32'h404 + 32'(4 * i), tg);
            tick();
        end
        qj = 5'd5; qk = 5'd6;
        cdb(1, 5'd5, 32'hAB, 32'd0);
        #1;
        chk("t6_vj_ready_byp", 64'(vj_ready), 64'd1);
        chk("t6_vj_byp", 64'(vj), 64'hAB);
        chk("t6_vk_pending", 64'(vk_ready), 64'd0);
        tick();
        qk = 5'd0;
        #1;
        chk("t6_vj_ready_st", 64'(vj_ready), 64'd1);
        chk("t6_vj_st", 64'(vj), 64'hAB);
        chk("t6_vk_null", 64'(vk_ready), 64'd0);
        qk = 5'd9;
        #1;
        chk("t6_vk_unocc", 64'(vk_ready), 64'd0);
        cdb(0, 5'd1, 32'h61, 32'd0);
        tick();
        rst = 1'b1;
        issue_valid = 1'b1; issue_opcode = OP_ALU;
        tick();
        chk("t6_rst_cvalid", 64'(commit_valid), 64'd0);
        chk("t6_rst_count", 64'(count_out), 64'd0);
        chk("t6_rst_alloc", 64'(alloc_tag), 64'd1);
        chk("t6_rst_full", 64'(full), 64'd0);
        chk("t6_rst_rollback", 64'(rollback), 64'd0);
        chk("t6_rst_rbpc", 64'(rollback_pc), 64'd0);
        chk("t6_rst_ctag", 64'(commit_tag), 64'd0);
        chk("t6_rst_cdata", 64'(commit_data), 64'd0);
        chk("t6_rst_vj", 64'(vj_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("t6_post_cvalid", 64'(commit_valid), 64'd0);
        chk("t6_post_count", 64'(count_out), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
